// File: rtl/block_buffer.sv
// block_buffer: block RAM filled by a length-bounded write sequencer, drained by a streaming/random read sequencer
module block_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 512,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
    localparam int CNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  blk_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_done,
    input  logic                  rd_start,
    input  logic                  rd_en,
    input  logic                  rand_en,
    input  logic [ADDR_WIDTH-1:0] rand_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_done,
    output logic [CNT_WIDTH-1:0]  fill_count,
    output logic                  busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d, fill_count_q, fill_count_d;
    logic                  wr_done_q, wr_done_d;
    logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_done_q, rd_done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_en, wr_last, rd_last_word, do_start;
    logic [CNT_WIDTH-1:0]  eff_len;

    // Zero or oversize lengths mean "whole buffer"; starts are honoured only in IDLE/FULL
    always_comb begin
        eff_len      = (blk_len == '0 || blk_len > DEPTH_C) ? DEPTH_C : blk_len;
        do_start     = start && (state_q == IDLE || state_q == FULL);
        wr_en        = (state_q == FILL) && wr_valid && !reset;
        wr_last      = ({1'b0, wr_ptr_q} == len_q - CNT_WIDTH'(1));
        rd_last_word = ({1'b0, rd_ptr_q} == len_q - CNT_WIDTH'(1));
    end

    // Sequencer next-state: fill, stream drain with 1-cycle read latency, random reads while full
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        fill_count_d = fill_count_q;
        wr_done_d    = wr_done_q;
        rd_valid_d   = 1'b0;
        rd_last_d    = 1'b0;
        rd_done_d    = 1'b0;
        rd_data_d    = rd_data_q;
        if (do_start) begin
            state_d      = FILL;
            wr_ptr_d     = '0;
            fill_count_d = '0;
            len_d        = eff_len;
            wr_done_d    = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
            fill_count_d = fill_count_q + CNT_WIDTH'(1);
            state_d      = wr_last ? FULL : FILL;
            wr_done_d    = wr_last;
        end else if (state_q == FULL && rd_start) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
        end else if (state_q == FULL && rand_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rand_addr];
        end else if (state_q == DRAIN && rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            rd_last_d  = rd_last_word;
            rd_done_d  = rd_last_word;
            state_d    = rd_last_word ? FULL : DRAIN;
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            fill_count_q <= '0;
            wr_done_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            fill_count_q <= fill_count_d;
            wr_done_q    <= wr_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_done_q    <= rd_done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign wr_ready   = (state_q == FILL);
    assign busy       = (state_q == FILL) || (state_q == DRAIN);
    assign wr_done    = wr_done_q;
    assign fill_count = fill_count_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;
    assign rd_done    = rd_done_q;
endmodule

// File: tb/tb_block_buffer.sv
// tb_block_buffer: directed self-checking bench for block_buffer
module tb_block_buffer;
    logic       clk = 0, reset = 1, start = 0, wr_valid = 0, rd_start = 0, rd_en = 0, rand_en = 0;
    logic [9:0] blk_len = 0;
    logic [7:0] wr_data = 0, rd_data;
    logic [8:0] rand_addr = 0;
    logic       wr_ready, wr_done, rd_valid, rd_last, rd_done, busy;
    logic [9:0] fill_count;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] a_words [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0] d_words [3] = '{8'hD0, 8'hD1, 8'hD2};
    logic       pat [6] = '{1, 0, 1, 1, 0, 1};

    block_buffer dut (
        .clk(clk), .reset(reset), .start(start), .blk_len(blk_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
        .rd_start(rd_start), .rd_en(rd_en), .rand_en(rand_en), .rand_addr(rand_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_done(rd_done),
        .fill_count(fill_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_wr_done"}, wr_done, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_rd_done"}, rd_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fill_count"}, fill_count, 0);
    endtask

    initial begin
        int k;
        tick();
        tick();
        chk_idle_outs("reset");
        reset = 0;
        rd_start = 1;
        rand_en = 1;
        tick();
        rd_start = 0;
        rand_en = 0;
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_valid", rd_valid, 0);

        // fill 4 words
        start = 1;
        blk_len = 4;
        tick();
        start = 0;
        chk("fill_ready", wr_ready, 1);
        chk("fill_busy", busy, 1);
        wr_valid = 1;
        for (int i = 0; i < 4; i++) begin
            wr_data = a_words[i];
            tick();
            chk("fill_count_step", fill_count, i + 1);
            chk("fill_ready_step", wr_ready, i < 3);
        end
        wr_valid = 0;
        chk("fill4_done", wr_done, 1);
        chk("fill4_busy", busy, 0);

        // continuous drain
        rd_start = 1;
        tick();
        rd_start = 0;
        chk("drain_busy", busy, 1);
        chk("drain_novalid", rd_valid, 0);
        rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, a_words[i]);
            chk("drain_last", rd_last, i == 3);
            chk("drain_done", rd_done, i == 3);
        end
        rd_en = 0;
        tick();
        chk("drain_after_valid", rd_valid, 0);
        chk("drain_after_done", rd_done, 0);
        chk("drain_hold_data", rd_data, 8'hA3);
        chk("drain_after_busy", busy, 0);
        chk("drain_keeps_wr_done", wr_done, 1);

        // drain with bubbles
        rd_start = 1;
        tick();
        rd_start = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            rd_en = pat[i];
            tick();
            chk("bubble_valid", rd_valid, pat[i]);
            if (pat[i]) begin
                chk("bubble_data", rd_data, a_words[k]);
                chk("bubble_last", rd_last, k == 3);
                k++;
            end
        end
        rd_en = 0;
        chk("bubble_busy", busy, 0);

        // full-depth fill via blk_len = 0
        start = 1;
        blk_len = 0;
        tick();
        start = 0;
        chk("deep_wr_done_cleared", wr_done, 0);
        wr_valid = 1;
        for (int i = 0; i < 512; i++) begin
            wr_data = 8'(i);
            tick();
            if (i == 510) chk("deep_ready_510", wr_ready, 1);
        end
        wr_valid = 0;
        chk("deep_ready", wr_ready, 0);
        chk("deep_done", wr_done, 1);
        chk("deep_count", fill_count, 512);
        rand_en = 1;
        rand_addr = 511;
        tick();
        rand_en = 0;
        chk("rand_valid", rd_valid, 1);
        chk("rand_data", rd_data, 8'hFF);
        chk("rand_last", rd_last, 0);
        tick();
        chk("rand_after_valid", rd_valid, 0);
        chk("rand_hold_data", rd_data, 8'hFF);

        // async reset mid-fill
        start = 1;
        blk_len = 8;
        tick();
        start = 0;
        wr_valid = 1;
        wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        chk("pre_reset_count", fill_count, 2);
        #2;
        reset = 1;
        wr_data = 8'h99;
        #1;
        chk_idle_outs("async_reset");
        tick();
        tick();
        reset = 0;
        tick();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_count", fill_count, 0);
        wr_valid = 0;
        start = 1;
        blk_len = 2;
        tick();
        start = 0;
        wr_valid = 1;
        wr_data = 8'hC0;
        tick();
        wr_data = 8'hC1;
        tick();
        wr_valid = 0;
        chk("refill2_done", wr_done, 1);
        rand_en = 1;
        rand_addr = 2;
        tick();
        chk("stale_addr2", rd_data, 8'h02);
        rand_addr = 0;
        tick();
        rand_en = 0;
        chk("refill_addr0", rd_data, 8'hC0);

        // start and rd_start together in FULL: start wins
        start = 1;
        rd_start = 1;
        blk_len = 3;
        tick();
        start = 0;
        rd_start = 0;
        chk("prio_ready", wr_ready, 1);
        chk("prio_wr_done", wr_done, 0);
        chk("prio_novalid", rd_valid, 0);
        wr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            wr_data = d_words[i];
            tick();
        end
        wr_valid = 0;
        chk("prio_fill_done", wr_done, 1);
        rd_start = 1;
        tick();
        rd_start = 0;
        rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("redrain_data", rd_data, d_words[i]);
            chk("redrain_last", rd_last, i == 2);
        end
        rd_en = 0;
        tick();
        chk("redrain_end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
